// File: rtl/fnd_pkg.sv
// Shared types and helpers for the 4-digit FND scan path.
// Build macro FND_LEADING_ZERO_BLANK_EN is consumed by fnd_scan_controller.
package fnd_pkg;

    localparam int FND_DIGITS = 4;
    localparam int FND_SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        LIT,
        GUARD
    } fnd_scan_state_t;

    typedef logic [3:0] bcd_nibble_t;

    function automatic bcd_nibble_t nibble_of(
        input logic [4*FND_DIGITS-1:0] word,
        input logic [FND_SEL_W-1:0]    sel
    );
        return word[{sel, 2'b00} +: 4];
    endfunction

    // True when this digit and every higher digit are zero; digit 0 always shows.
    function automatic logic leading_zero(
        input logic [4*FND_DIGITS-1:0] word,
        input logic [FND_SEL_W-1:0]    sel
    );
        return (sel != '0) && ((word >> {sel, 2'b00}) == '0);
    endfunction

endpackage

// File: rtl/fnd_tick_counter.sv
// Terminal-count counter with synchronous clear and a combinational wrap pulse.
// The terminal value is a run-time input so one counter serves several phases.
module fnd_tick_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_reg;

    assign wrap  = en && (count_reg == terminal);
    assign count = count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear || wrap) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit scan scheduler with guard blanking and frame-aligned word updates.
// Optional build macro: FND_LEADING_ZERO_BLANK_EN (suppresses leading zero digits).
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int CLK_DIV      = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_En,
    input  logic [4*FND_DIGITS-1:0] i_Value,
    input  logic                    i_Load,
    output logic                    o_LoadAck,
    output logic                    o_Pending,
    output logic                    o_En,
    output logic [FND_SEL_W-1:0]    o_DigitSelect,
    output logic [3:0]              o_Value,
    output logic                    o_FrameDone
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LIT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] FD_CNT     = CW'(CLK_DIV - 2);
    localparam logic [FND_SEL_W-1:0] LAST_DIGIT = FND_SEL_W'(FND_DIGITS - 1);

    fnd_scan_state_t             state_reg, state_next;
    logic [FND_SEL_W-1:0]        digit_reg, digit_next;
    logic [4*FND_DIGITS-1:0]     active_reg, active_next;
    logic [4*FND_DIGITS-1:0]     pending_reg, pending_next;
    logic                        pending_flag_reg, pending_flag_next;
    logic                        en_reg, en_next;
    logic [FND_SEL_W-1:0]        sel_reg, sel_next;
    bcd_nibble_t                 value_reg, value_next;
    logic                        ack_reg, ack_next;
    logic                        frame_done_reg, frame_done_next;

    logic          copy;
    logic          blank;
    logic          cnt_en;
    logic          wrap;
    logic [CW-1:0] count;
    logic [CW-1:0] terminal;

    assign cnt_en   = i_En && (state_reg != IDLE);
    assign terminal = (state_reg == LIT) ? LIT_LAST : GUARD_LAST;

    fnd_tick_counter #(
        .WIDTH(CW)
    ) u_tick (
        .clk     (i_clk),
        .rst     (i_reset),
        .clear   (!cnt_en),
        .en      (cnt_en),
        .terminal(terminal),
        .count   (count),
        .wrap    (wrap)
    );

    always_comb begin
        state_next = state_reg;
        digit_next = digit_reg;
        copy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_En) begin
                    state_next = LIT;
                    digit_next = '0;
                    copy       = pending_flag_reg;
                end
            end
            LIT: begin
                if (!i_En) begin
                    state_next = IDLE;
                    digit_next = '0;
                end else if (wrap) begin
                    state_next = GUARD;
                end
            end
            GUARD: begin
                if (!i_En) begin
                    state_next = IDLE;
                    digit_next = '0;
                end else if (wrap) begin
                    state_next = LIT;
                    digit_next = digit_reg + 1'b1;
                    copy       = pending_flag_reg && (digit_reg == LAST_DIGIT);
                end
            end
            default: begin
                state_next = IDLE;
                digit_next = '0;
            end
        endcase

        // Copy reads the old pending word; a same-cycle load re-arms for the next frame.
        active_next       = copy ? pending_reg : active_reg;
        pending_next      = i_Load ? i_Value : pending_reg;
        pending_flag_next = i_Load ? 1'b1 : (copy ? 1'b0 : pending_flag_reg);

`ifdef FND_LEADING_ZERO_BLANK_EN
        blank = leading_zero(active_next, digit_next);
`else
        blank = 1'b0;
`endif

        en_next    = (state_next == LIT) && !blank;
        sel_next   = sel_reg;
        value_next = value_reg;
        if (state_next == LIT) begin
            sel_next   = digit_next;
            value_next = nibble_of(active_next, digit_next);
        end else if (state_next == IDLE) begin
            sel_next = '0;
        end
        ack_next = copy;
        // LIT always starts at count 0, so CLK_DIV-2 is the edge before the final lit cycle.
        frame_done_next = (state_reg == LIT) && i_En && (digit_reg == LAST_DIGIT)
                          && (count == FD_CNT);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg        <= IDLE;
            digit_reg        <= '0;
            active_reg       <= '0;
            pending_reg      <= '0;
            pending_flag_reg <= 1'b0;
            en_reg           <= 1'b0;
            sel_reg          <= '0;
            value_reg        <= '0;
            ack_reg          <= 1'b0;
            frame_done_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            digit_reg        <= digit_next;
            active_reg       <= active_next;
            pending_reg      <= pending_next;
            pending_flag_reg <= pending_flag_next;
            en_reg           <= en_next;
            sel_reg          <= sel_next;
            value_reg        <= value_next;
            ack_reg          <= ack_next;
            frame_done_reg   <= frame_done_next;
        end
    end

    assign o_LoadAck     = ack_reg;
    assign o_Pending     = pending_flag_reg;
    assign o_En          = en_reg;
    assign o_DigitSelect = sel_reg;
    assign o_Value       = value_reg;
    assign o_FrameDone   = frame_done_reg;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: frame-position model checked every cycle plus literal checkpoints.
module tb_fnd_scan_controller;

    localparam int CLK_DIV      = 4;
    localparam int GUARD_CYCLES = 2;
    localparam int PHASE        = CLK_DIV + GUARD_CYCLES;
    localparam int FRAME        = 4 * PHASE;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_En;
    logic [15:0] i_Value;
    logic        i_Load;
    logic        o_LoadAck;
    logic        o_Pending;
    logic        o_En;
    logic [1:0]  o_DigitSelect;
    logic [3:0]  o_Value;
    logic        o_FrameDone;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fnd_scan_controller #(
        .CLK_DIV     (CLK_DIV),
        .GUARD_CYCLES(GUARD_CYCLES)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_En         (i_En),
        .i_Value      (i_Value),
        .i_Load       (i_Load),
        .o_LoadAck    (o_LoadAck),
        .o_Pending    (o_Pending),
        .o_En         (o_En),
        .o_DigitSelect(o_DigitSelect),
        .o_Value      (o_Value),
        .o_FrameDone  (o_FrameDone)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Model: position within a 4*(CLK_DIV+GUARD) frame while running.
    logic        run;
    int          pos;
    logic [15:0] active, pw, old_w;
    logic        pf, old_f;
    logic        m_ack;
    logic [3:0]  m_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run = 1'b0; pos = 0; active = '0; pw = '0; pf = 1'b0;
            m_ack = 1'b0; m_val = '0;
        end else begin
            old_w = pw; old_f = pf; m_ack = 1'b0;
            if (!run) begin
                if (i_En) begin
                    run = 1'b1; pos = 0;
                    if (old_f) begin active = old_w; pf = 1'b0; m_ack = 1'b1; end
                end
            end else if (!i_En) begin
                run = 1'b0;
            end else begin
                pos = (pos + 1) % FRAME;
                if (pos == 0 && old_f) begin active = old_w; pf = 1'b0; m_ack = 1'b1; end
            end
            if (i_Load) begin pw = i_Value; pf = 1'b1; end
            if (run) m_val = 4'(active >> (4 * (pos / PHASE)));
        end
    end

    function automatic logic exp_en();
        int d;
        logic bl;
        d  = pos / PHASE;
        bl = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
        bl = (d != 0) && ((active >> (4 * d)) == 16'h0);
`endif
        return run && ((pos % PHASE) < CLK_DIV) && !bl;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_en",   32'(o_En),          32'(exp_en()));
            chk("cyc_sel",  32'(o_DigitSelect), run ? 32'(pos / PHASE) : 32'd0);
            chk("cyc_val",  32'(o_Value),       32'(m_val));
            chk("cyc_ack",  32'(o_LoadAck),     32'(m_ack));
            chk("cyc_pend", 32'(o_Pending),     32'(pf));
            chk("cyc_fd",   32'(o_FrameDone),   32'(run && pos == 3 * PHASE + CLK_DIV - 1));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] w);
        i_Value = w; i_Load = 1'b1;
        step(1);
        i_Load = 1'b0;
    endtask

    task automatic chk_lit(input string name, input logic [1:0] sel, input logic [3:0] val);
        chk({name, "_en"},  32'(o_En), 32'd1);
        chk({name, "_sel"}, 32'(o_DigitSelect), 32'(sel));
        chk({name, "_val"}, 32'(o_Value), 32'(val));
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_en"},   32'(o_En), 32'd0);
        chk({name, "_sel"},  32'(o_DigitSelect), 32'd0);
        chk({name, "_val"},  32'(o_Value), 32'd0);
        chk({name, "_ack"},  32'(o_LoadAck), 32'd0);
        chk({name, "_pend"}, 32'(o_Pending), 32'd0);
        chk({name, "_fd"},   32'(o_FrameDone), 32'd0);
    endtask

    initial begin
        rst = 1'b1; i_En = 1'b0; i_Value = '0; i_Load = 1'b0;
        step(3);
        chk_zero("rst");
        #2 rst = 1'b0;
        step(1);

        // Scan order with 4321
        load(16'h4321);
        chk("pend_set", 32'(o_Pending), 32'd1);
        i_En = 1'b1;
        step(1);                                    // pos 0
        chk_lit("f1d0", 2'd0, 4'h1);
        chk("f1_ack", 32'(o_LoadAck), 32'd1);
        chk("f1_pend", 32'(o_Pending), 32'd0);
        step(4);                                    // pos 4, guard
        chk("f1_guard_en", 32'(o_En), 32'd0);
        chk("f1_guard_sel", 32'(o_DigitSelect), 32'd0);
        step(2);  chk_lit("f1d1", 2'd1, 4'h2);      // pos 6
        step(6);  chk_lit("f1d2", 2'd2, 4'h3);      // pos 12
        step(6);  chk_lit("f1d3", 2'd3, 4'h4);      // pos 18
        step(3);  chk("f1_fd", 32'(o_FrameDone), 32'd1);  // pos 21
        step(1);  chk("f1_fd_end", 32'(o_FrameDone), 32'd0);

        // Frame-boundary update during digit 1
        step(8);                                    // pos 6 of next frame
        load(16'h8765);                             // pos 7
        chk("f2_pend", 32'(o_Pending), 32'd1);
        step(5);  chk_lit("f2d2", 2'd2, 4'h3);
        step(6);  chk_lit("f2d3", 2'd3, 4'h4);
        step(6);                                    // pos 0
        chk_lit("f3d0", 2'd0, 4'h5);
        chk("f3_ack", 32'(o_LoadAck), 32'd1);
        chk("f3_pend", 32'(o_Pending), 32'd0);

        // Overwrite: last load wins, one ack
        step(1);  load(16'h1111);                   // pos 2
        step(7);  load(16'h2222);                   // pos 10
        step(14);                                   // pos 0
        chk("ow_ack", 32'(o_LoadAck), 32'd1);
        chk_lit("ow_d0", 2'd0, 4'h2);
        step(6);  chk_lit("ow_d1", 2'd1, 4'h2);
        step(6);  chk_lit("ow_d2", 2'd2, 4'h2);
        step(6);  chk_lit("ow_d3", 2'd3, 4'h2);     // pos 18

        // Disable in guard of digit 2, pending retained and applied on re-enable
        step(7);  load(16'h0950);                   // pos 2
        step(14);                                   // pos 16
        i_En = 1'b0;
        step(1);
        chk("dis_en", 32'(o_En), 32'd0);
        chk("dis_sel", 32'(o_DigitSelect), 32'd0);
        chk("dis_pend", 32'(o_Pending), 32'd1);
        step(3);
        i_En = 1'b1;
        step(1);
        chk_lit("re_d0", 2'd0, 4'h0);
        chk("re_ack", 32'(o_LoadAck), 32'd1);
        step(6);  chk_lit("re_d1", 2'd1, 4'h5);
        step(6);  chk_lit("re_d2", 2'd2, 4'h9);
        step(6);                                    // pos 18
`ifdef FND_LEADING_ZERO_BLANK_EN
        chk("re_d3_blank", 32'(o_En), 32'd0);
`else
        chk_lit("re_d3", 2'd3, 4'h0);
`endif

        // Asynchronous reset mid-LIT
        #2 rst = 1'b1;
        #1 chk_zero("arst");
        step(1);
        #2 rst = 1'b0;
        step(1);  chk_lit("ar_d0", 2'd0, 4'h0);     // pos 0
        step(3);  chk("ar_p3_en", 32'(o_En), 32'd1);
        step(1);  chk("ar_p4_en", 32'(o_En), 32'd0);
        step(1);  chk("ar_p5_en", 32'(o_En), 32'd0);
        step(1);  chk("ar_p6_en", 32'(o_En), 32'd1);

`ifdef FND_LEADING_ZERO_BLANK_EN
        i_En = 1'b0; step(1);
        load(16'h0050);
        i_En = 1'b1; step(1);
        chk_lit("lz_d0", 2'd0, 4'h0);
        step(6);  chk_lit("lz_d1", 2'd1, 4'h5);
        step(6);  chk("lz_d2_en", 32'(o_En), 32'd0); chk("lz_d2_sel", 32'(o_DigitSelect), 32'd2);
        step(6);  chk("lz_d3_en", 32'(o_En), 32'd0); chk("lz_d3_sel", 32'(o_DigitSelect), 32'd3);
        i_En = 1'b0; step(1);
        load(16'h0000);
        i_En = 1'b1; step(1);
        chk_lit("z_d0", 2'd0, 4'h0);
        step(6);  chk("z_d1_en", 32'(o_En), 32'd0);
        step(6);  chk("z_d2_en", 32'(o_En), 32'd0);
        step(6);  chk("z_d3_en", 32'(o_En), 32'd0);
`endif

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
- Time-multiplexing scan scheduler for the 4-digit FND path.
- Holds a 4-digit BCD word and sequences digits 0..3 into the existing BCD-to-FND decoder by driving its enable, digit-select and 4-bit value inputs.
- Inserts a blanking guard between digits to suppress ghosting.
- Double-buffers host updates so a new word only appears at a frame boundary.

Parameters:
- CLK_DIV, 100000, clock cycles each digit is lit (>=2).
- GUARD_CYCLES, 16, blank cycles between digits (>=1, < CLK_DIV).
- Counter width is $clog2(CLK_DIV), shared by lit and guard counting.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_En  in  1  scan enable; 0 forces blank and idle
- i_Value  in  16  BCD word; nibble n = digit n, digit 0 = [3:0]
- i_Load  in  1  single-cycle request to capture i_Value
- o_LoadAck  out  1  1-cycle pulse when the pending word becomes active
- o_Pending  out  1  captured word waiting for frame boundary
- o_En  out  1  to decoder enable
- o_DigitSelect  out  2  to decoder digit select
- o_Value  out  4  to decoder value
- o_FrameDone  out  1  1-cycle pulse at end of digit 3 lit phase

Behaviour:
- Reset (async, any state) values:
  - State IDLE.
  - o_En=0, o_DigitSelect=0, o_Value=0, o_LoadAck=0, o_Pending=0, o_FrameDone=0.
  - Active and pending words = 16'h0000, counter = 0.
- All outputs are registered.
- FSM states: IDLE, LIT, GUARD.
  - IDLE: o_En=0. When i_En=1: load the pending word into active if o_Pending=1, then go to LIT with digit 0 and counter 0.
  - LIT:
    - o_En=1, o_DigitSelect=digit, o_Value=active[4*digit+:4].
    - When counter reaches CLK_DIV-1: clear counter and go to GUARD.
    - If digit==3, pulse o_FrameDone in that same cycle.
  - GUARD:
    - o_En=0; o_DigitSelect and o_Value hold their previous values.
    - When counter reaches GUARD_CYCLES-1: set digit=digit+1 (2-bit wrap, 3->0), clear counter, go to LIT.
    - On the 3->0 wrap with o_Pending=1: copy pending to active, clear o_Pending, pulse o_LoadAck. This happens in the same cycle as the transition, so digit 0 of the new frame shows the new word.
- i_En=0 in LIT or GUARD: next cycle goes to IDLE with o_En=0 and digit cleared. The pending word is retained.
- i_Load: captures i_Value into pending and sets o_Pending on the next edge.
  - A repeated i_Load before the boundary overwrites pending (last one wins). Only one o_LoadAck is issued.
  - i_Load in the same cycle as the wrap copy: the copy uses the old pending word. The new capture then sets o_Pending=1 again for the next frame.
  - i_Load while in IDLE is applied on the IDLE->LIT transition, with an o_LoadAck pulse.
- Nibbles >9 are passed through unchanged; the decoder defines their font.
- Frame period = 4*(CLK_DIV+GUARD_CYCLES) cycles.

Optional Feature:
- Macro: FND_LEADING_ZERO_BLANK_EN.
- Defined:
  - While in LIT, o_En is forced to 0 for a digit whose nibble is 0 and all of whose higher-numbered nibbles are 0.
  - Digit 0 is never blanked, so 0000 shows "0".
  - Timing, o_FrameDone and o_DigitSelect are unchanged.
- Undefined: all digits are lit, as described above.

Decomposition:
- Shared package fnd_pkg holds:
  - FND_DIGITS=4 and FND_SEL_W=2.
  - State enum typedef fnd_scan_state_t {IDLE, LIT, GUARD}.
  - BCD nibble typedef.
- One natural sub-module: fnd_tick_counter, a parameterised terminal-count counter with clear and wrap pulse.
- The controller instantiates the counter and, at top level, connects its outputs to the BCD-to-FND decoder.

Test Plan:
- Reset and enable: assert i_reset mid-LIT (CLK_DIV=4, GUARD_CYCLES=2) -> all outputs 0 immediately. Release with i_En=1 -> digit 0 is lit for 4 cycles, then o_En=0 for 2 cycles.
- Scan order: load 16'h4321 then run one frame -> (sel,value) sequence (0,1),(1,2),(2,3),(3,4). Each is lit for 4 cycles. One o_FrameDone pulse in the last LIT cycle of digit 3.
- Frame-boundary update: load 16'h4321; during digit 1, pulse i_Load with 16'h8765 -> o_Pending=1 and digits 2,3 still show 3,4. At wrap: o_LoadAck pulses, o_Pending=0, digit 0 shows 5.
- Overwrite: two i_Load pulses (16'h1111 then 16'h2222) within one frame -> a single o_LoadAck and the next frame shows all 2s.
- Disable: drop i_En during GUARD of digit 2 -> o_En=0 and IDLE next cycle. Re-enable -> restart at digit 0 and the pending word is applied.
- Macro-defined run with 16'h0050 -> digit 3 and digit 2 blanked, digit 1 shows 5, digit 0 shows 0. With 16'h0000 -> only digit 0 is lit.
